// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel/line counters, registered syncs and blank,
// a once-per-frame tick at the start of vertical blanking and a slow 2-bit animation index.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned ANIM_PERIOD = 8
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_tick,
    output logic [1:0] anim_frame
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PC_W    = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode compares are done in 11 bits so region edges equal to 1024 stay representable.
    localparam logic [10:0] H_VIS_END   = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END   = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(ANIM_PERIOD - 1);

    logic [9:0]      r_hc;
    logic [9:0]      r_vc;
    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_anim;
    logic            r_hs;
    logic            r_vs;
    logic            r_blank;
    logic            r_tick;

    logic [9:0]  w_hc_next;
    logic [9:0]  w_vc_next;
    logic [10:0] w_hx;
    logic [10:0] w_vy;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_blank_next;
    logic        w_tick_next;

    always_comb begin
        w_hc_next = r_hc + 10'd1;
        w_vc_next = r_vc;
        if (r_hc == H_LAST) begin
            w_hc_next = '0;
            w_vc_next = (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
        end
    end

    // Outputs are decoded from the next counter value so they line up with DrawX/DrawY.
    always_comb begin
        w_hx         = {1'b0, w_hc_next};
        w_vy         = {1'b0, w_vc_next};
        w_hs_next    = !((w_hx >= H_SYNC_BEG) && (w_hx < H_SYNC_END));
        w_vs_next    = !((w_vy >= V_SYNC_BEG) && (w_vy < V_SYNC_END));
        w_blank_next = (w_hx < H_VIS_END) && (w_vy < V_VIS_END);
        w_tick_next  = (w_hx == 11'd0) && (w_vy == V_VIS_END);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc    <= '0;
            r_vc    <= '0;
            r_pc    <= '0;
            r_anim  <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_hc    <= w_hc_next;
            r_vc    <= w_vc_next;
            r_hs    <= w_hs_next;
            r_vs    <= w_vs_next;
            r_blank <= w_blank_next;
            r_tick  <= w_tick_next;
            if (w_tick_next) begin
                if (r_pc == PC_LAST) begin
                    r_pc   <= '0;
                    r_anim <= r_anim + 2'd1;
                end else begin
                    r_pc <= r_pc + PC_W'(1);
                end
            end
        end
    end

    assign DrawX      = r_hc;
    assign DrawY      = r_vc;
    assign hs         = r_hs;
    assign vs         = r_vs;
    assign blank      = r_blank;
    assign frame_tick = r_tick;
    assign anim_frame = r_anim;

endmodule
